ecpri_rma_req_tx: RTL
=====================

Name: ecpri_rma_req_tx

Overview:
- Initiator-side eCPRI transmitter that builds one Remote Memory Access (RMA) request frame (message type 0x04) into the Ethernet transmit RAM, one byte per clock.
- It is the opposite end of the eCPRI receive path, which parses RMA requests from the Ethernet RAM.
- For write requests, payload bytes are fetched from the CPRI payload RAM and appended after the header.
- Both RAMs are ram_dp_sr_sw instances (synchronous write, registered read, 1-cycle read latency); chip selects are driven externally and held high.

Parameters:
- DATA_WIDTH, 8, RAM data width (must be 8).
- ADDR_WIDTH, 16, RAM address width.
- MAX_DATA_LEN, 1024, largest accepted data_len in bytes.
- ETH_TYPE, 16'hAEFE, Ethertype written at frame bytes 12-13.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request strobe; sampled only in IDLE.
- rma_rw  in  1  0 = read request, 1 = write request.
- rma_id  in  8  Remote Memory Access ID.
- element_id  in  16  target element ID.
- mem_addr  in  48  remote memory address.
- data_len  in  16  access length in bytes.
- dst_mac  in  48  destination MAC.
- src_mac  in  48  source MAC.
- addr_0  out  ADDR_WIDTH  Ethernet TX RAM address.
- data_0  inout  DATA_WIDTH  Ethernet TX RAM data; driven only while we_0=1, otherwise 'hz.
- we_0  out  1  Ethernet TX RAM write enable.
- oe_0  out  1  Ethernet TX RAM output enable; always 0.
- addr_1  out  ADDR_WIDTH  payload RAM address.
- data_1  inout  DATA_WIDTH  payload RAM data; never driven by this block.
- we_1  out  1  payload RAM write enable; always 0.
- oe_1  out  1  payload RAM read enable.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  1-cycle completion pulse.
- err  out  1  set together with done if the request was rejected.
- frame_len  out  16  bytes written for the last frame; valid from done onward.

Behaviour:
- Reset values: all outputs 0 and data_0 = 'hz; state returns to IDLE.
- Reset mid-frame abandons the frame; bytes already written to the Ethernet TX RAM stay there.
- States: IDLE -> HDR -> (PRIME -> PLD) -> DONE -> IDLE.
- IDLE, start=1:
  - Latch all request inputs.
  - If rma_rw=1 and data_len > MAX_DATA_LEN: go to DONE with err=1 and frame_len=0; no RAM writes occur.
  - Otherwise go to HDR with hdr_idx=0.
- start while not in IDLE is ignored.
- HDR (30 cycles): each cycle drives we_0=1, addr_0=hdr_idx, data_0=byte[hdr_idx], then increments hdr_idx. Byte layout, multi-byte fields MSB first:
  - bytes 0-5: dst_mac.
  - bytes 6-11: src_mac.
  - bytes 12-13: ETH_TYPE.
  - byte 14: 8'h10 (revision 1, C=0).
  - byte 15: 8'h04.
  - bytes 16-17: payload_size = 12 + (rma_rw ? data_len : 0), 16-bit, wraps are impossible given MAX_DATA_LEN.
  - byte 18: rma_id.
  - byte 19: {3'b0, rma_rw, 4'h0} (read/write nibble, request nibble 0).
  - bytes 20-21: element_id.
  - bytes 22-27: mem_addr.
  - bytes 28-29: data_len.
- After hdr_idx=29: go to PRIME if rma_rw=1 and data_len != 0; otherwise go to DONE.
- PRIME (1 cycle): oe_1=1, addr_1=0, we_0=0.
- PLD (data_len cycles, k = 0 .. data_len-1):
  - we_0=1, addr_0=30+k, data_0 = data_1 as registered by the RAM.
  - Concurrently oe_1=1 and addr_1=k+1 while k+1 < data_len; oe_1=0 on the last cycle.
- DONE (1 cycle): done=1; frame_len = 30 + (rma_rw ? data_len : 0); busy=0. Next cycle IDLE.
- Latency from start accepted at edge E0:
  - Read request: done in cycle 31.
  - Write request: done in cycle 32 + data_len.
- Frame is not padded to the 60-byte Ethernet minimum; the MAC layer pads.
- A read request writes data_len into the Length field but appends no data.
- busy=1 in HDR, PRIME and PLD.

Test Plan:
- Read request: rma_rw=0, rma_id=8'h5A, element_id=16'h0102, mem_addr=48'h0000_1234_5678, data_len=16'h0020 -> RAM bytes 14..29 = 10 04 00 0C 5A 00 01 02 00 00 12 34 56 78 00 20; done 31 cycles after start; frame_len=30; err=0.
- Write request: rma_rw=1, data_len=8, payload RAM preloaded mem[i]=i -> bytes 16-17 = 00 14, byte 19 = 10, bytes 30-37 = 00..07; frame_len=38; done at cycle 40.
- Oversize write: data_len=MAX_DATA_LEN+1 -> done and err in cycle 1, we_0 never asserted, frame_len=0.
- Zero-length write: data_len=0, rma_rw=1 -> no PRIME/PLD, oe_1 never asserted, frame_len=30, payload_size=000C.
- Start while busy: second start pulse at cycle 10 ignored, latched fields unchanged; a start pulse in the cycle after done is accepted.
- Reset asserted at cycle 15 of HDR -> next cycle busy=0, we_0=0, data_0='hz; a following start produces a complete, correct frame.

Source files
------------

// File: rtl/ecpri_rma_req_tx_if.sv
// Request/status bundle between an RMA requester and the eCPRI RMA request transmitter.
interface ecpri_rma_req_tx_if;
  logic        start;
  logic        rma_rw;
  logic [7:0]  rma_id;
  logic [15:0] element_id;
  logic [47:0] mem_addr;
  logic [15:0] data_len;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] frame_len;

  modport master (
    output start, rma_rw, rma_id, element_id, mem_addr, data_len, dst_mac, src_mac,
    input  busy, done, err, frame_len
  );

  modport slave (
    input  start, rma_rw, rma_id, element_id, mem_addr, data_len, dst_mac, src_mac,
    output busy, done, err, frame_len
  );
endinterface

// File: rtl/ecpri_rma_req_tx.sv
// Builds one eCPRI RMA request frame (msg type 0x04) into the Ethernet TX RAM, one byte per
// clock, appending write payload fetched from the payload RAM.
module ecpri_rma_req_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned MAX_DATA_LEN = 1024,
  parameter logic [15:0] ETH_TYPE     = 16'hAEFE
) (
  input  logic                  clk,
  input  logic                  reset,
  ecpri_rma_req_tx_if.slave     req,
  output logic [ADDR_WIDTH-1:0] addr_0,
  inout  wire  [DATA_WIDTH-1:0] data_0,
  output logic                  we_0,
  output logic                  oe_0,
  output logic [ADDR_WIDTH-1:0] addr_1,
  inout  wire  [DATA_WIDTH-1:0] data_1,
  output logic                  we_1,
  output logic                  oe_1
);

  typedef enum logic [2:0] {StIdle, StHdr, StPrime, StPld, StDone} state_e;

  localparam logic [16:0] MaxLen = 17'(MAX_DATA_LEN);

  state_e      state_q, state_d;
  logic [4:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] pld_idx_q, pld_idx_d;
  logic        err_q, err_d;
  logic [15:0] flen_q, flen_d;
  logic        latch;

  logic        rw_q;
  logic [7:0]  id_q;
  logic [15:0] elem_q;
  logic [47:0] maddr_q;
  logic [15:0] len_q;
  logic [47:0] dst_q;
  logic [47:0] src_q;

  logic                  oversize;
  logic [15:0]           pld_len;
  logic [15:0]           payload_size;
  logic [15:0]           frame_total;
  logic [239:0]          hdr;
  logic [7:0]            hdr_byte;
  logic [15:0]           pld_next;
  logic                  last_pld;
  logic [DATA_WIDTH-1:0] wdata;

  assign oversize     = req.rma_rw && ({1'b0, req.data_len} > MaxLen);
  assign pld_len      = rw_q ? len_q : 16'd0;
  assign payload_size = 16'd12 + pld_len;
  assign frame_total  = 16'd30 + pld_len;
  assign pld_next     = pld_idx_q + 16'd1;
  assign last_pld     = (pld_idx_q == len_q - 16'd1);

  // Header image, byte 0 in the top bits; all multi-byte fields MSB first.
  assign hdr = {dst_q, src_q, ETH_TYPE, 8'h10, 8'h04, payload_size, id_q,
                {3'b000, rw_q, 4'h0}, elem_q, maddr_q, len_q};
  assign hdr_byte = hdr[{5'd29 - hdr_idx_q, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hdr_idx_q <= '0;
      pld_idx_q <= '0;
      err_q     <= 1'b0;
      flen_q    <= '0;
      rw_q      <= 1'b0;
      id_q      <= '0;
      elem_q    <= '0;
      maddr_q   <= '0;
      len_q     <= '0;
      dst_q     <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      pld_idx_q <= pld_idx_d;
      err_q     <= err_d;
      flen_q    <= flen_d;
      if (latch) begin
        rw_q    <= req.rma_rw;
        id_q    <= req.rma_id;
        elem_q  <= req.element_id;
        maddr_q <= req.mem_addr;
        len_q   <= req.data_len;
        dst_q   <= req.dst_mac;
        src_q   <= req.src_mac;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    pld_idx_d = pld_idx_q;
    err_d     = err_q;
    flen_d    = flen_q;
    latch     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req.start) begin
          latch = 1'b1;
          if (oversize) begin
            state_d = StDone;
            err_d   = 1'b1;
            flen_d  = '0;
          end else begin
            state_d   = StHdr;
            hdr_idx_d = '0;
            err_d     = 1'b0;
          end
        end
      end
      StHdr: begin
        hdr_idx_d = hdr_idx_q + 5'd1;
        if (hdr_idx_q == 5'd29) begin
          if (rw_q && (len_q != 16'd0)) begin
            state_d = StPrime;
          end else begin
            state_d = StDone;
            flen_d  = frame_total;
          end
        end
      end
      StPrime: begin
        state_d   = StPld;
        pld_idx_d = '0;
      end
      StPld: begin
        pld_idx_d = pld_next;
        if (last_pld) begin
          state_d = StDone;
          flen_d  = frame_total;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_0   = 1'b0;
    addr_0 = '0;
    wdata  = '0;
    oe_1   = 1'b0;
    addr_1 = '0;
    unique case (state_q)
      StHdr: begin
        we_0   = 1'b1;
        addr_0 = ADDR_WIDTH'(hdr_idx_q);
        wdata  = DATA_WIDTH'(hdr_byte);
      end
      StPrime: oe_1 = 1'b1;
      StPld: begin
        // Payload RAM read data lags its address by one cycle, so fetch k+1 while writing k.
        we_0   = 1'b1;
        addr_0 = ADDR_WIDTH'(16'd30 + pld_idx_q);
        wdata  = data_1;
        if (pld_next < len_q) begin
          oe_1   = 1'b1;
          addr_1 = ADDR_WIDTH'(pld_next);
        end
      end
      default: ;
    endcase
  end

  assign data_0 = we_0 ? wdata : 'z;
  assign oe_0   = 1'b0;
  assign we_1   = 1'b0;

  assign req.busy      = (state_q == StHdr) || (state_q == StPrime) || (state_q == StPld);
  assign req.done      = (state_q == StDone);
  assign req.err       = (state_q == StDone) && err_q;
  assign req.frame_len = flen_q;

endmodule
